// File: rtl/fb_pkg.sv
// Shared types and defaults for the framebuffer RAM arbiter and its
// read-return tag pipeline.
package fb_pkg;

    localparam int FB_ADDR_W = 24;
    localparam int FB_DATA_W = 24;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_DISP = 2'd1,
        OWN_DRAW = 2'd2
    } owner_t;

    typedef enum logic {
        DISP_PRI   = 1'b0,
        DRAW_FORCE = 1'b1
    } arb_state_t;

    // Owner tag for this cycle's grant; writes return no data, so they tag NONE.
    function automatic owner_t read_owner(input logic disp_win,
                                          input logic draw_win,
                                          input logic draw_we);
        owner_t tag;
        if (disp_win) begin
            tag = OWN_DISP;
        end else if (draw_win && !draw_we) begin
            tag = OWN_DRAW;
        end else begin
            tag = OWN_NONE;
        end
        return tag;
    endfunction

endpackage

// File: rtl/fb_rd_tag_pipe.sv
// Owner-tag shift register: a tag entered with a grant emerges DEPTH cycles
// later, lined up with the RAM read data it belongs to.
module fb_rd_tag_pipe
    import fb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic   clk,
    input  logic   rst,
    input  owner_t tag_in,
    output owner_t tag_out
);

    owner_t stage_r [DEPTH];

    // Shift tags one stage per cycle; reset drops every in-flight tag.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_r[i] <= OWN_NONE;
            end
        end else begin
            stage_r[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign tag_out = stage_r[DEPTH-1];

endmodule

// File: rtl/fb_mem_arbiter.sv
// Single-port framebuffer RAM arbiter: fixed display priority with a
// starvation override for draw, registered RAM command, tagged read return.
module fb_mem_arbiter
    import fb_pkg::*;
#(
    parameter int ADDR_W     = FB_ADDR_W,
    parameter int DATA_W     = FB_DATA_W,
    parameter int RD_LATENCY = 1,
    parameter int MAX_WAIT   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_gnt,
    output logic              disp_rvalid,
    output logic [DATA_W-1:0] disp_rdata,
    input  logic              draw_req,
    input  logic              draw_we,
    input  logic [ADDR_W-1:0] draw_addr,
    input  logic [DATA_W-1:0] draw_wdata,
    output logic              draw_gnt,
    output logic              draw_rvalid,
    output logic [DATA_W-1:0] draw_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              draw_forced
);

    localparam int               CNT_W    = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    arb_state_t       state_r;
    logic [CNT_W-1:0] wait_cnt_r;
    logic [CNT_W-1:0] wait_cnt_nxt_s;
    logic             disp_win_s;
    logic             draw_win_s;
    logic             forced_s;
    owner_t           tag_in_s;
    owner_t           tag_out_s;

    // Grant decode; nothing is granted while reset is asserted.
    always_comb begin
        disp_win_s = 1'b0;
        draw_win_s = 1'b0;
        forced_s   = 1'b0;
        if (rst) begin
            disp_win_s = 1'b0;
        end else begin
            case ({disp_req, draw_req})
                2'b10: disp_win_s = 1'b1;
                2'b01: draw_win_s = 1'b1;
                2'b11: begin
                    if (state_r == DRAW_FORCE) begin
                        draw_win_s = 1'b1;
                        forced_s   = 1'b1;
                    end else begin
                        disp_win_s = 1'b1;
                    end
                end
                default: disp_win_s = 1'b0;
            endcase
        end
    end

    // Starvation count: only consecutive lost draw cycles accumulate.
    always_comb begin
        wait_cnt_nxt_s = wait_cnt_r;
        if (!draw_req || draw_win_s) begin
            wait_cnt_nxt_s = '0;
        end else if (wait_cnt_r != WAIT_MAX) begin
            wait_cnt_nxt_s = wait_cnt_r + CNT_ONE;
        end else begin
            wait_cnt_nxt_s = wait_cnt_r;
        end
    end

    // Arbitration state tracks the saturated counter so the override is a
    // single-bit decode in the grant path.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_r <= '0;
            state_r    <= DISP_PRI;
        end else begin
            wait_cnt_r <= wait_cnt_nxt_s;
            state_r    <= (wait_cnt_nxt_s == WAIT_MAX) ? DRAW_FORCE : DISP_PRI;
        end
    end

    // Registered RAM command; address and data hold when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (disp_win_s) begin
            mem_en    <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= disp_addr;
        end else if (draw_win_s) begin
            mem_en    <= 1'b1;
            mem_we    <= draw_we;
            mem_addr  <= draw_addr;
            mem_wdata <= draw_wdata;
        end else begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
        end
    end

    assign tag_in_s = read_owner(disp_win_s, draw_win_s, draw_we);

    // One stage covers the command register, the rest the RAM read latency.
    fb_rd_tag_pipe #(
        .DEPTH (RD_LATENCY + 1)
    ) u_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .tag_in  (tag_in_s),
        .tag_out (tag_out_s)
    );

    assign disp_gnt    = disp_win_s;
    assign draw_gnt    = draw_win_s;
    assign draw_forced = forced_s;
    assign disp_rvalid = (tag_out_s == OWN_DISP);
    assign draw_rvalid = (tag_out_s == OWN_DRAW);
    assign disp_rdata  = mem_rdata;
    assign draw_rdata  = mem_rdata;

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// Scoreboard bench for fb_mem_arbiter: two instances (read latency 1 and 2)
// share one stimulus stream; each has its own RAM model and return checker.
`timescale 1ns/1ps
module tb_fb_mem_arbiter;
    import fb_pkg::*;

    localparam int AW = 24;
    localparam int DW = 24;
    localparam int MW = 8;

    typedef struct packed {
        owner_t        own;
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } drw_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          disp_req;
    logic [AW-1:0] disp_addr;
    logic          draw_req;
    logic          draw_we;
    logic [AW-1:0] draw_addr;
    logic [DW-1:0] draw_wdata;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [AW-1:0] disp_q [$];
    drw_t          draw_q [$];
    logic [DW-1:0] shadow [logic [AW-1:0]];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return a ^ 24'h5A5A5A;
    endfunction

    function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
        return shadow.exists(a) ? shadow[a] : init_val(a);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : gi
        localparam int LAT = g + 1;

        logic          disp_gnt, disp_rvalid, draw_gnt, draw_rvalid;
        logic          mem_en, mem_we, draw_forced;
        logic [DW-1:0] disp_rdata, draw_rdata, mem_wdata, mem_rdata;
        logic [AW-1:0] mem_addr;
        exp_t          sb [$];
        logic [DW-1:0] ram [logic [AW-1:0]];

        fb_mem_arbiter #(
            .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(LAT), .MAX_WAIT(MW)
        ) u_dut (
            .clk(clk), .rst(rst),
            .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
            .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
            .draw_req(draw_req), .draw_we(draw_we), .draw_addr(draw_addr),
            .draw_wdata(draw_wdata), .draw_gnt(draw_gnt),
            .draw_rvalid(draw_rvalid), .draw_rdata(draw_rdata),
            .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
            .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
            .draw_forced(draw_forced)
        );

        // RAM model: command sampled mid-cycle, read data appears LAT cycles later.
        initial begin
            logic [DW-1:0] pipe [4];
            logic [DW-1:0] cap;
            for (int k = 0; k < 4; k++) pipe[k] = 24'h0;
            mem_rdata = 24'h0;
            forever begin
                @(negedge clk);
                if (mem_en && mem_we) ram[mem_addr] = mem_wdata;
                if (mem_en && !mem_we)
                    cap = ram.exists(mem_addr) ? ram[mem_addr] : init_val(mem_addr);
                else
                    cap = 24'hBAD0BA;
                @(posedge clk);
                #1;
                for (int k = 3; k > 0; k--) pipe[k] = pipe[k-1];
                pipe[0]   = cap;
                mem_rdata = pipe[LAT-1];
            end
        end

        // Monitor: command stage, read returns against the scoreboard, then
        // push expectations for this cycle's grants.
        initial begin
            logic          exp_en, exp_we;
            logic [AW-1:0] exp_addr;
            logic [DW-1:0] exp_wdata;
            exp_t          e;
            exp_en = 1'b0; exp_we = 1'b0; exp_addr = 24'h0; exp_wdata = 24'h0;
            forever begin
                @(negedge clk);
                chk($sformatf("i%0d_mem_en", g), mem_en, exp_en);
                chk($sformatf("i%0d_mem_we", g), mem_we, exp_we);
                if (exp_en) chk($sformatf("i%0d_mem_addr", g), mem_addr, exp_addr);
                if (exp_we) chk($sformatf("i%0d_mem_wdata", g), mem_wdata, exp_wdata);
                chk($sformatf("i%0d_one_gnt", g), disp_gnt & draw_gnt, 1'b0);
                chk($sformatf("i%0d_gnt_wo_req", g),
                    (disp_gnt & ~disp_req) | (draw_gnt & ~draw_req), 1'b0);
                while (sb.size() > 0 && sb[0].due < cyc) begin
                    e = sb.pop_front();
                    chk($sformatf("i%0d_rv_missing_due", g), cyc, e.due);
                end
                if (disp_rvalid || draw_rvalid) begin
                    if (sb.size() == 0) begin
                        chk($sformatf("i%0d_rv_unexpected", g), {disp_rvalid, draw_rvalid}, 2'b00);
                    end else begin
                        e = sb.pop_front();
                        chk($sformatf("i%0d_rv_cycle", g), cyc, e.due);
                        chk($sformatf("i%0d_rv_disp", g), disp_rvalid, e.own == OWN_DISP);
                        chk($sformatf("i%0d_rv_draw", g), draw_rvalid, e.own == OWN_DRAW);
                        chk($sformatf("i%0d_rdata", g),
                            (e.own == OWN_DISP) ? disp_rdata : draw_rdata, e.data);
                    end
                end
                if (disp_gnt) sb.push_back('{OWN_DISP, exp_data(disp_addr), cyc + 1 + LAT});
                if (draw_gnt && !draw_we) sb.push_back('{OWN_DRAW, exp_data(draw_addr), cyc + 1 + LAT});
                if (rst) begin
                    exp_en = 1'b0; exp_we = 1'b0; exp_addr = 24'h0; exp_wdata = 24'h0;
                    sb.delete();
                end else if (disp_gnt) begin
                    exp_en = 1'b1; exp_we = 1'b0; exp_addr = disp_addr;
                end else if (draw_gnt) begin
                    exp_en = 1'b1; exp_we = draw_we; exp_addr = draw_addr; exp_wdata = draw_wdata;
                end else begin
                    exp_en = 1'b0; exp_we = 1'b0;
                end
            end
        end
    end

    // Display requester: holds the head item until granted.
    initial begin : disp_agent
        logic g;
        disp_req = 1'b0; disp_addr = 24'h0;
        forever begin
            @(negedge clk);
            g = gi[0].disp_gnt;
            @(posedge clk);
            #1;
            if (g && disp_q.size() > 0) void'(disp_q.pop_front());
            if (disp_q.size() > 0) begin
                disp_req = 1'b1; disp_addr = disp_q[0];
            end else begin
                disp_req = 1'b0;
            end
        end
    end

    // Draw requester: same hold-until-grant handshake.
    initial begin : draw_agent
        logic g;
        draw_req = 1'b0; draw_we = 1'b0; draw_addr = 24'h0; draw_wdata = 24'h0;
        forever begin
            @(negedge clk);
            g = gi[0].draw_gnt;
            @(posedge clk);
            #1;
            if (g && draw_q.size() > 0) void'(draw_q.pop_front());
            if (draw_q.size() > 0) begin
                draw_req = 1'b1; draw_we = draw_q[0].we;
                draw_addr = draw_q[0].addr; draw_wdata = draw_q[0].wdata;
            end else begin
                draw_req = 1'b0;
            end
        end
    end

    // Protocol watch and reference-memory update on granted draw writes.
    initial begin : proto
        logic disp_pend, draw_pend;
        disp_pend = 1'b0; draw_pend = 1'b0;
        forever begin
            @(negedge clk);
            if (disp_pend) chk("disp_req_dropped", disp_req, 1'b1);
            if (draw_pend) chk("draw_req_dropped", draw_req, 1'b1);
            disp_pend = disp_req && !gi[0].disp_gnt;
            draw_pend = draw_req && !gi[0].draw_gnt;
            if (gi[0].draw_gnt && draw_we) shadow[draw_addr] = draw_wdata;
        end
    end

    task automatic wait_drain();
        int n;
        n = 0;
        while ((disp_q.size() != 0 || draw_q.size() != 0 ||
                gi[0].sb.size() != 0 || gi[1].sb.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", n >= 100, 1'b0);
        repeat (2) @(negedge clk);
    endtask

    initial begin : main
        logic exp_draw;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ctrl0", {gi[0].mem_en, gi[0].mem_we, gi[0].disp_gnt, gi[0].draw_gnt,
                          gi[0].disp_rvalid, gi[0].draw_rvalid, gi[0].draw_forced}, 7'h0);
        chk("rst_ctrl1", {gi[1].mem_en, gi[1].mem_we, gi[1].disp_gnt, gi[1].draw_gnt,
                          gi[1].disp_rvalid, gi[1].draw_rvalid, gi[1].draw_forced}, 7'h0);
        chk("rst_mem_addr", {gi[0].mem_addr, gi[1].mem_addr}, 48'h0);
        chk("rst_mem_wdata", {gi[0].mem_wdata, gi[1].mem_wdata}, 48'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);

        // Display stream, back-to-back grants, addresses 0..9.
        for (int k = 0; k < 10; k++) disp_q.push_back(AW'(k));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t2_disp_gnt", gi[0].disp_gnt, 1'b1);
            if (i > 0) chk("t2_mem_addr", gi[0].mem_addr, AW'(i - 1));
        end
        wait_drain();

        // Contention: display 8 cycles, then forced draw, repeating.
        for (int k = 0; k < 22; k++) disp_q.push_back(24'h000100 + AW'(k));
        draw_q.push_back('{1'b0, 24'h000200, 24'h0});
        draw_q.push_back('{1'b0, 24'h000201, 24'h0});
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            exp_draw = (i == 8) || (i == 17);
            chk($sformatf("t3_disp_gnt_%0d", i), gi[0].disp_gnt, !exp_draw);
            chk($sformatf("t3_draw_gnt_%0d", i), gi[0].draw_gnt, exp_draw);
            chk($sformatf("t3_forced_%0d", i), gi[0].draw_forced, exp_draw);
        end
        wait_drain();

        // Draw write, then display read-back of the same word.
        draw_q.push_back('{1'b1, 24'h000123, 24'hABCDEF});
        @(negedge clk);
        chk("t4_wr_gnt", gi[0].draw_gnt, 1'b1);
        @(negedge clk);
        chk("t4_mem_we", gi[0].mem_we, 1'b1);
        chk("t4_mem_addr", gi[0].mem_addr, 24'h000123);
        chk("t4_mem_wdata", gi[0].mem_wdata, 24'hABCDEF);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_no_draw_rvalid", gi[0].draw_rvalid | gi[1].draw_rvalid, 1'b0);
        end
        wait_drain();
        disp_q.push_back(24'h000123);
        @(negedge clk);
        chk("t4_rd_gnt", gi[0].disp_gnt, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("t4_rv_lat1", gi[0].disp_rvalid, 1'b1);
        chk("t4_rdata_lat1", gi[0].disp_rdata, 24'hABCDEF);
        @(negedge clk);
        chk("t4_rv_lat2", gi[1].disp_rvalid, 1'b1);
        chk("t4_rdata_lat2", gi[1].disp_rdata, 24'hABCDEF);
        wait_drain();

        // Lone draw read on the latency-2 instance.
        draw_q.push_back('{1'b0, 24'h000010, 24'h123456});
        @(negedge clk);
        chk("t5_draw_gnt", gi[1].draw_gnt, 1'b1);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            chk($sformatf("t5_draw_rvalid_%0d", i), gi[1].draw_rvalid, i == 3);
            chk($sformatf("t5_disp_rvalid_%0d", i), gi[1].disp_rvalid, 1'b0);
        end
        chk("t5_draw_rdata", gi[1].draw_rdata, 24'h5A5A4A);
        wait_drain();

        // Counter clear: 5 losses, display idles, normal draw grant, then 8 more.
        for (int k = 0; k < 5; k++) disp_q.push_back(24'h000300 + AW'(k));
        draw_q.push_back('{1'b0, 24'h000310, 24'h0});
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("t6a_disp_gnt_%0d", i), gi[0].disp_gnt, i < 5);
            chk($sformatf("t6a_draw_gnt_%0d", i), gi[0].draw_gnt, i == 5);
            chk($sformatf("t6a_forced_%0d", i), gi[0].draw_forced, 1'b0);
        end
        for (int k = 0; k < 10; k++) disp_q.push_back(24'h000320 + AW'(k));
        draw_q.push_back('{1'b0, 24'h000330, 24'h0});
        for (int i = 6; i < 16; i++) begin
            @(negedge clk);
            chk($sformatf("t6b_draw_gnt_%0d", i), gi[0].draw_gnt, i == 14);
            chk($sformatf("t6b_forced_%0d", i), gi[0].draw_forced, i == 14);
        end
        wait_drain();

        // Reset during a display stream.
        for (int k = 0; k < 30; k++) disp_q.push_back(24'h000400 + AW'(k));
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("t1_gnt_rst_a", {gi[0].disp_gnt, gi[0].draw_gnt, gi[1].disp_gnt, gi[1].draw_gnt}, 4'h0);
        @(negedge clk);
        chk("t1_gnt_rst_b", {gi[0].disp_gnt, gi[0].draw_gnt, gi[1].disp_gnt, gi[1].draw_gnt}, 4'h0);
        chk("t1_mem_en_rst", {gi[0].mem_en, gi[1].mem_en}, 2'b00);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            if (j < 2) chk($sformatf("t1_no_rv0_%0d", j), gi[0].disp_rvalid, 1'b0);
            chk($sformatf("t1_no_rv1_%0d", j), gi[1].disp_rvalid, 1'b0);
        end
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule

// File: doc/fb_mem_arbiter.md
Name: fb_mem_arbiter

Overview:
Arbiter for the single-port framebuffer RAM. It is shared by two requesters: the display fetch path, which reads pixel words into the VGA line FIFO, and the draw path, which writes notes and graphics into the framebuffer and can read them back. Display has fixed priority. A starvation counter guarantees the draw path a slot after MAX_WAIT consecutive lost cycles. The block registers the RAM command and routes read data back to the owning requester with a valid strobe.

Parameters:
ADDR_W, 24, framebuffer address width
DATA_W, 24, pixel word width
RD_LATENCY, 1, RAM cycles from registered command to mem_rdata valid (legal 1..4)
MAX_WAIT, 8, consecutive draw-losing cycles before draw is forced (legal 1..255)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
disp_req  in  1  display read request, held until granted
disp_addr  in  ADDR_W  display read address
disp_gnt  out  1  display request accepted this cycle (combinational)
disp_rvalid  out  1  disp_rdata valid
disp_rdata  out  DATA_W  display read data
draw_req  in  1  draw request, held until granted
draw_we  in  1  1 = write, 0 = read
draw_addr  in  ADDR_W  draw address
draw_wdata  in  DATA_W  draw write data
draw_gnt  out  1  draw request accepted this cycle (combinational)
draw_rvalid  out  1  draw_rdata valid
draw_rdata  out  DATA_W  draw read data
mem_en  out  1  RAM access strobe (registered)
mem_we  out  1  RAM write enable (registered)
mem_addr  out  ADDR_W  RAM address (registered)
mem_wdata  out  DATA_W  RAM write data (registered)
mem_rdata  in  DATA_W  RAM read data
draw_forced  out  1  pulse: the current draw grant came from starvation override

Behaviour:
- Clock is clk; reset is rst, synchronous, active-high.
- Reset state: all outputs 0, starvation counter 0, tag pipeline cleared.
- Handshake:
  - A requester holds req, addr, we and wdata stable until it sees gnt high at a clock edge.
  - It may present a new request in the very next cycle, so back-to-back grants are allowed.
  - gnt is never asserted while the matching req is low.
- Grant function (per cycle, combinational from req and state):
  - Only one requester asserting: that requester wins.
  - Both asserting and wait_cnt < MAX_WAIT: display wins.
  - Both asserting and wait_cnt == MAX_WAIT: draw wins, and draw_forced = 1 that cycle.
  - Exactly one gnt per cycle with any req high.
- Arbitration state:
  - Two states, DISP_PRI (default) and DRAW_FORCE.
  - The state is DRAW_FORCE whenever wait_cnt == MAX_WAIT.
  - A draw grant returns the state to DISP_PRI.
- Starvation counter wait_cnt, width clog2(MAX_WAIT+1):
  - Increments when draw_req = 1 and draw_gnt = 0.
  - Clears on draw_gnt, or when draw_req = 0.
  - Saturates at MAX_WAIT.
- Command stage:
  - A grant in cycle N drives mem_en = 1 in cycle N+1, with the winner's addr and wdata.
  - mem_we = 1 only for a draw grant with draw_we = 1.
  - No grant in cycle N: mem_en = mem_we = 0 in cycle N+1; mem_addr/mem_wdata hold.
- Read return:
  - Each read grant pushes an owner tag (NONE/DISP/DRAW) into a RD_LATENCY+1 deep pipeline.
  - A read granted in cycle N gives rvalid for exactly one cycle, in cycle N+1+RD_LATENCY, on the owning side only.
  - rdata = mem_rdata (combinational pass-through); it is don't-care while rvalid = 0.
  - Writes produce no rvalid.
  - Returned reads keep grant order.
- Reset mid-operation:
  - In-flight reads are discarded; no rvalid is issued for them after reset.
  - The counter clears.
  - Requests present during reset are not granted until the first cycle after rst deasserts.
- Simultaneous draw grant and draw_req drop: impossible by the handshake rule; the bench flags a req drop before gnt as a protocol error.

Decomposition:
- Shared package fb_pkg holds:
  - owner encoding OWN_NONE = 2'd0, OWN_DISP = 2'd1, OWN_DRAW = 2'd2;
  - default ADDR_W/DATA_W;
  - arbitration state encodings.
- Sub-module fb_rd_tag_pipe: parameterised owner-tag shift register, depth RD_LATENCY+1, clear on rst.

Test Plan:
1. Reset during traffic: disp_req streaming, assert rst 2 cycles -> mem_en = 0 and all gnt = 0 during reset; no disp_rvalid in the RD_LATENCY+1 cycles after release.
2. Display stream, RD_LATENCY = 1: disp_req held, addr 0..9 back-to-back -> disp_gnt every cycle; mem_addr = k one cycle after grant k; disp_rvalid two cycles after grant, data matching the RAM model in order.
3. Contention, MAX_WAIT = 8: both req high continuously from cycle 0 -> display granted cycles 0-7, draw granted cycle 8 with draw_forced = 1, then repeating 8:1.
4. Draw write then display read: draw_we = 1, addr 0x000123, wdata 0xABCDEF -> mem_we = 1 next cycle, no draw_rvalid; a later display read of 0x000123 returns 0xABCDEF.
5. Draw read with RD_LATENCY = 2: lone draw read of 0x000010 -> draw_rvalid exactly 3 cycles after draw_gnt; disp_rvalid stays 0.
6. Counter clear: draw_req waits 5 cycles behind display, then display idles 1 cycle -> draw granted normally with draw_forced = 0; a new contention run needs 8 more losses before forcing.
